// File: rtl/qnigma_chacha20_pkg.sv
// Shared ChaCha20 types, block constants and the quarter-round used by the keystream core.
package qnigma_chacha20_pkg;
    localparam int unsigned KST_BLK_BITS = 512;

    typedef logic [255:0]            cha_key_t;
    typedef logic [95:0]             cha_non_t;
    typedef logic [31:0]             cha_ctr_t;
    typedef logic [0:0]              cha_tag_t;
    typedef logic [KST_BLK_BITS-1:0] cha_kst_blk_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} cha_eng_t;

    // "expand 32-byte k", little-endian words 0..3 of the block state
    localparam logic [127:0] CHA_SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic cha_kst_blk_t qr(input cha_kst_blk_t v, input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
        logic [31:0] wa, wb, wc, wd;
        wa = v[32*a +: 32];
        wb = v[32*b +: 32];
        wc = v[32*c +: 32];
        wd = v[32*d +: 32];
        wa = wa + wb; wd = rotl(wd ^ wa, 16);
        wc = wc + wd; wb = rotl(wb ^ wc, 12);
        wa = wa + wb; wd = rotl(wd ^ wa, 8);
        wc = wc + wd; wb = rotl(wb ^ wc, 7);
        v[32*a +: 32] = wa;
        v[32*b +: 32] = wb;
        v[32*c +: 32] = wc;
        v[32*d +: 32] = wd;
        return v;
    endfunction
endpackage

// File: rtl/qnigma_math_chacha20_kst.sv
// ChaCha20 block core: one column or diagonal round per cycle, 20 cycles per 512-bit block.
module qnigma_math_chacha20_kst
    import qnigma_chacha20_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  cha_key_t     key,
    input  cha_non_t     non,
    input  cha_ctr_t     ctr,
    input  cha_tag_t     tag_i,
    output logic         run,
    output logic         val,
    output cha_kst_blk_t kst,
    output cha_tag_t     tag
);
    cha_kst_blk_t st, init, rnd_nx;
    logic [4:0]   rnd;

    always_comb begin
        rnd_nx = st;
        if (!rnd[0]) begin
            rnd_nx = qr(rnd_nx, 0, 4, 8, 12);
            rnd_nx = qr(rnd_nx, 1, 5, 9, 13);
            rnd_nx = qr(rnd_nx, 2, 6, 10, 14);
            rnd_nx = qr(rnd_nx, 3, 7, 11, 15);
        end else begin
            rnd_nx = qr(rnd_nx, 0, 5, 10, 15);
            rnd_nx = qr(rnd_nx, 1, 6, 11, 12);
            rnd_nx = qr(rnd_nx, 2, 7, 8, 13);
            rnd_nx = qr(rnd_nx, 3, 4, 9, 14);
        end
    end

    always_comb begin
        kst = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            kst[32*i +: 32] = st[32*i +: 32] + init[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run  <= 1'b0;
            val  <= 1'b0;
            rnd  <= '0;
            st   <= '0;
            init <= '0;
            tag  <= '0;
        end else begin
            val <= 1'b0;
            if (run) begin
                st  <= rnd_nx;
                rnd <= rnd + 5'd1;
                if (rnd == 5'd19) begin
                    run <= 1'b0;
                    val <= 1'b1;
                end
            end else if (req) begin
                st   <= {non, ctr, key, CHA_SIGMA};
                init <= {non, ctr, key, CHA_SIGMA};
                rnd  <= '0;
                run  <= 1'b1;
                tag  <= tag_i;
            end
        end
    end
endmodule

// File: rtl/qnigma_math_chacha20_kst_fifo.sv
// DEPTH-entry buffer of 512-bit keystream blocks with synchronous flush.
module qnigma_math_chacha20_kst_fifo
    import qnigma_chacha20_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  cha_kst_blk_t  din,
    output cha_kst_blk_t  dout,
    output logic [CW-1:0] cnt,
    output logic          nempty
);
    cha_kst_blk_t  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= inc(wp);
            if (pop)  rp <= inc(rp);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign dout   = mem[rp];
    assign nempty = (cnt != '0);
endmodule

// File: rtl/qnigma_math_chacha20_stream.sv
// ChaCha20 stream XOR stage: keystream prefetch engine, word indexer and output register.
module qnigma_math_chacha20_stream
    import qnigma_chacha20_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lod,
    input  cha_key_t      key,
    input  cha_non_t      non,
    input  cha_ctr_t      ini,
    input  logic [DW-1:0] dat_i,
    input  logic          val_i,
    input  logic          sof_i,
    input  logic          eof_i,
    output logic          cts_i,
    output logic [DW-1:0] dat_o,
    output logic          val_o,
    output logic          sof_o,
    output logic          eof_o,
    input  logic          rdy_o,
    output logic          ovf
);
    localparam int unsigned WPB = KST_BLK_BITS / DW;
    localparam int unsigned WW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    cha_eng_t      st, st_nx;
    cha_key_t      key_q;
    cha_non_t      non_q;
    cha_ctr_t      bctr;
    cha_tag_t      epoch, core_tag;
    cha_kst_blk_t  core_kst, fifo_dout;
    logic          req, core_run, core_val, push, pop, acc, fifo_nempty;
    logic [CW-1:0] fifo_cnt;
    logic [WW-1:0] widx;
    logic [DW-1:0] kword;

    qnigma_math_chacha20_kst u_kst (
        .clk(clk), .rst(rst), .req(req), .key(key_q), .non(non_q), .ctr(bctr), .tag_i(epoch),
        .run(core_run), .val(core_val), .kst(core_kst), .tag(core_tag)
    );

    qnigma_math_chacha20_kst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .flush(lod), .push(push), .pop(pop), .din(core_kst),
        .dout(fifo_dout), .cnt(fifo_cnt), .nempty(fifo_nempty)
    );

    // Only WAIT owns the core's next result; results landing in REQ are leftovers of an old session.
    assign push  = core_val & (st == ST_WAIT) & (core_tag == epoch) & ~lod;
    assign cts_i = fifo_nempty & (~val_o | rdy_o) & ~lod;
    assign acc   = val_i & cts_i;
    assign pop   = acc & ((widx == WW'(WPB - 1)) | eof_i);
    assign kword = fifo_dout[32'(widx) * DW +: DW];

    always_ff @(posedge clk) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        req   = 1'b0;
        unique case (st)
            ST_IDLE: if (lod) st_nx = ST_REQ;
            ST_REQ: begin
                if (!lod && !ovf && !core_run && !core_val && (fifo_cnt < CW'(DEPTH))) begin
                    req   = 1'b1;
                    st_nx = ST_WAIT;
                end
            end
            ST_WAIT: if (lod || core_val) st_nx = ST_REQ;
            default: st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
            non_q <= '0;
            bctr  <= '0;
            epoch <= '0;
            ovf   <= 1'b0;
        end else if (lod) begin
            key_q <= key;
            non_q <= non;
            bctr  <= ini;
            epoch <= ~epoch;
            ovf   <= 1'b0;
        end else if (req) begin
            bctr <= bctr + 32'd1;
            if (bctr == '1) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || lod || pop) widx <= '0;
        else if (acc)          widx <= widx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_o <= '0;
            val_o <= 1'b0;
            sof_o <= 1'b0;
            eof_o <= 1'b0;
        end else if (acc) begin
            dat_o <= dat_i ^ kword;
            val_o <= 1'b1;
            sof_o <= sof_i;
            eof_o <= eof_i;
        end else if (rdy_o) begin
            val_o <= 1'b0;
            sof_o <= 1'b0;
            eof_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qnigma_math_chacha20_stream.sv
// Scoreboard bench: randomized packets and backpressure against a ChaCha20 reference model.
module tb_qnigma_math_chacha20_stream;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned WPB   = 512 / DW;

    logic          clk = 1'b0, rst = 1'b1, lod = 1'b0;
    logic [255:0]  key = '0;
    logic [95:0]   non = '0;
    logic [31:0]   ini = '0;
    logic [DW-1:0] dat_i = '0;
    logic          val_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
    logic          cts_i;
    logic [DW-1:0] dat_o;
    logic          val_o, sof_o, eof_o, ovf;
    logic          rdy_o = 1'b0;

    qnigma_math_chacha20_stream #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .lod(lod), .key(key), .non(non), .ini(ini),
        .dat_i(dat_i), .val_i(val_i), .sof_i(sof_i), .eof_i(eof_i), .cts_i(cts_i),
        .dat_o(dat_o), .val_o(val_o), .sof_o(sof_o), .eof_o(eof_o), .rdy_o(rdy_o), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } exp_t;

    int            n_pass = 0, n_total = 0;
    exp_t          sb[$];
    logic [DW-1:0] out_log[$];

    logic [255:0]  m_key;
    logic [95:0]   m_non;
    logic [31:0]   m_ctr;
    int unsigned   m_widx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        int unsigned  qi [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                                    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        logic [31:0]  s0 [16];
        logic [31:0]  w [16];
        logic [511:0] res;
        int unsigned  a, b, cc, d;
        s0[0] = 32'h61707865; s0[1] = 32'h3320646e; s0[2] = 32'h79622d32; s0[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s0[4 + i] = k[32*i +: 32];
        s0[12] = c;
        for (int i = 0; i < 3; i++) s0[13 + i] = n[32*i +: 32];
        w = s0;
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
                w[a]  = w[a] + w[b];   w[d] = rl(w[d] ^ w[a], 16);
                w[cc] = w[cc] + w[d];  w[b] = rl(w[b] ^ w[cc], 12);
                w[a]  = w[a] + w[b];   w[d] = rl(w[d] ^ w[a], 8);
                w[cc] = w[cc] + w[d];  w[b] = rl(w[b] ^ w[cc], 7);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = w[i] + s0[i];
        return res;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Each accepted word consumes the next keystream word; eof or a full block moves to the next counter.
    task automatic model_accept(input logic [DW-1:0] d, input logic s, input logic e);
        logic [511:0] blk;
        blk = chacha_block(m_key, m_non, m_ctr);
        sb.push_back('{d: d ^ blk[m_widx*DW +: DW], s: s, e: e});
        if (e || m_widx == WPB - 1) begin
            m_ctr++;
            m_widx = 0;
        end else begin
            m_widx++;
        end
    endtask

    task automatic do_lod(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        lod = 1'b1; key = k; non = n; ini = c;
        #1 chk("lod_cts_low", 64'(cts_i), 64'(0));
        m_key = k; m_non = n; m_ctr = c; m_widx = 0;
        @(negedge clk);
        lod = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic s, input logic e, output bit ok);
        ok = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        val_i = 1'b1; dat_i = d; sof_i = s; eof_i = e;
        for (int t = 0; t < 400; t++) begin
            #1;
            if (cts_i) begin
                @(posedge clk);
                model_accept(d, s, e);
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: cts_i=%b after 400 cycles, expected 1", cts_i);
        end
    endtask

    task automatic send_pkt(input int unsigned len, input bit with_eof);
        bit ok;
        for (int unsigned i = 0; i < len; i++) begin
            send_word(DW'($urandom), (i == 0), with_eof && (i == len - 1), ok);
            if (!ok) return;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_outstanding", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: random downstream ready, stall stability and scoreboard pop on each transfer.
    initial begin
        logic hold;
        exp_t held, x;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (hold && !rst)
                chk("stall_stable", 64'({val_o, sof_o, eof_o, dat_o}), 64'({1'b1, held.s, held.e, held.d}));
            rdy_o = ($urandom_range(0, 1) == 1);
            #2;
            if (val_o && rdy_o) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got %h, expected no output", dat_o);
                end else begin
                    x = sb.pop_front();
                    chk("data", 64'({dat_o, sof_o, eof_o}), 64'({x.d, x.s, x.e}));
                    out_log.push_back(dat_o);
                end
            end
            hold = val_o && !rdy_o;
            held = '{d: dat_o, s: sof_o, e: eof_o};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           ok;
        logic [255:0] k;
        logic [95:0]  n;
        logic [31:0]  w;
        int           seen, nw;
        string        pt;
        pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

        repeat (3) @(negedge clk);
        #1;
        chk("rst_val_o", 64'(val_o), 64'(0));
        chk("rst_sof_o", 64'(sof_o), 64'(0));
        chk("rst_eof_o", 64'(eof_o), 64'(0));
        chk("rst_dat_o", 64'(dat_o), 64'(0));
        chk("rst_ovf",   64'(ovf),   64'(0));
        chk("rst_cts_i", 64'(cts_i), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("nolod_cts_i", 64'(cts_i), 64'(0));
        chk("nolod_val_o", 64'(val_o), 64'(0));
        @(negedge clk);

        // RFC 8439 2.4.2 sunscreen vector
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        n = 96'h00000000_4a000000_00000000;
        do_lod(k, n, 32'd1);
        out_log.delete();
        nw = (pt.len() + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (4 * j + b < pt.len()) w[8*b +: 8] = pt[4*j + b];
            send_word(w, (j == 0), (j == nw - 1), ok);
        end
        drain();
        chk("rfc_word0", 64'(out_log[0]), 64'(32'h9a352e6e));
        chk("rfc_word1", 64'(out_log[1]), 64'(32'h80f96825));
        chk("rfc_nwords", 64'(out_log.size()), 64'(29));

        // short eof packet then a longer one
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        send_pkt(3, 1'b1);
        send_pkt(20, 1'b1);
        drain();

        // counter exhaustion
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, 32'hFFFF_FFFE);
        #1 chk("ovf_clear_early", 64'(ovf), 64'(0));
        @(negedge clk);
        send_pkt(2 * WPB, 1'b0);
        drain();
        chk("ovf_set", 64'(ovf), 64'(1));
        seen = 0;
        val_i = 1'b1; dat_i = '0;
        repeat (40) begin
            #1 if (cts_i) seen++;
            @(negedge clk);
        end
        val_i = 1'b0;
        chk("ovf_cts_blocked", 64'(seen), 64'(0));
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        #1 chk("ovf_cleared_by_lod", 64'(ovf), 64'(0));
        @(negedge clk);
        send_pkt(5, 1'b1);
        drain();

        // reload while a block is in flight, then again while the stale block still runs
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        repeat (25) @(negedge clk);
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        repeat (3) @(negedge clk);
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        send_pkt(20, 1'b1);
        drain();

        // reset mid-packet
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        send_pkt(10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk("midrst_val_o", 64'(val_o), 64'(0));
        chk("midrst_sof_o", 64'(sof_o), 64'(0));
        chk("midrst_eof_o", 64'(eof_o), 64'(0));
        chk("midrst_dat_o", 64'(dat_o), 64'(0));
        chk("midrst_ovf",   64'(ovf),   64'(0));
        chk("midrst_cts_i", 64'(cts_i), 64'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("postrst_cts_i", 64'(cts_i), 64'(0));
        chk("postrst_val_o", 64'(val_o), 64'(0));
        @(negedge clk);
        do_lod(rnd256(), {$urandom, $urandom, $urandom}, $urandom);
        send_pkt(5, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
